vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source for the colour generators: drives VGA_CLK-domain pixel coordinates x/y,
//  disp_en and the hsync/vsync pins for the VGA DAC.
//  Default mode is 1280x1024@60 Hz on a 108 MHz VGA_CLK.
//  The pattern blocks register RGB from x/y/disp_en; this block is the producer of that interface.
// PARAMETERS
//  H_ACT 1280  visible pixels per line
//  H_FP  48    horizontal front porch (clocks)
//  H_SW  112   hsync width (clocks)
//  H_BP  248   horizontal back porch (clocks)
//  V_ACT 1024  visible lines per frame
//  V_FP  1     vertical front porch (lines)
//  V_SW  3     vsync width (lines)
//  V_BP  38    vertical back porch (lines)
//  HS_POL 1    hsync active level
//  VS_POL 1    vsync active level
// PORTS
//  VGA_CLK     in   1   pixel clock
//  reset       in   1   synchronous, active-high
//  x           out  11  pixel column, 0..H_ACT-1 while disp_en, else 0
//  y           out  11  pixel row, 0..V_ACT-1 while disp_en, else 0
//  disp_en     out  1   high only inside the visible window
//  hsync       out  1   horizontal sync, level HS_POL when active
//  vsync       out  1   vertical sync, level VS_POL when active
//  line_start  out  1   1-clock pulse with first pixel of every line (incl. blanked lines)
//  frame_start out  1   1-clock pulse with pixel (0,0) of each frame
// BEHAVIOUR
//  - Counters and totals:
//    - H_TOT = H_ACT+H_FP+H_SW+H_BP (1688); V_TOT = V_ACT+V_FP+V_SW+V_BP (1066).
//    - h_cnt counts 0..H_TOT-1 and wraps to 0. v_cnt increments only on h_cnt wrap.
//    - v_cnt counts 0..V_TOT-1 and wraps to 0. Both counters are 11 bit.
//  - Each axis is decoded as a 4-state phase ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, by counter range:
//    - ACTIVE [0,ACT)
//    - FRONT [ACT,ACT+FP)
//    - SYNC [ACT+FP,ACT+FP+SW)
//    - BACK to TOT-1
//  - Output decode:
//    - disp_en = (h in ACTIVE) & (v in ACTIVE).
//    - hsync = HS_POL when h in SYNC, else ~HS_POL.
//    - vsync = VS_POL for the whole of every line whose v is in SYNC, else ~VS_POL.
//  - Output timing:
//    - All outputs are registered and mutually aligned. Each output shows the decode of the
//      counter value of the previous clock (latency 1).
//    - x/y are forced to 0 whenever disp_en=0, so downstream never sees out-of-window coordinates.
//  - Reset (sync): while reset=1, h_cnt=v_cnt=0 and the outputs hold these values:
//    - x=0, y=0, disp_en=0, line_start=0, frame_start=0
//    - hsync=~HS_POL, vsync=~VS_POL
//  - First clock after reset release:
//    - Outputs decode (0,0): disp_en=1, x=0, y=0, line_start=1, frame_start=1.
//    - Counters advance to (1,0).
//  - Reset asserted mid-frame: the next edge returns the block to the reset state; there is no
//    partial-line completion.
//  - Line wrap: x goes H_ACT-1 -> 0 (forced, blank) -> ... -> 0 with line_start; no glitch on sync.
//  - Frame wrap: last clock of line V_TOT-1 is followed by frame_start.
// TESTING
//  - Reset held 5 clocks -> every output at its reset value. Release -> next clock
//    disp_en=1, x=0, y=0, frame_start=1, line_start=1.
//  - One line:
//    - disp_en high exactly 1280 consecutive clocks; x steps 0..1279 by 1.
//    - hsync active exactly 112 clocks, starting 1328 clocks after line_start.
//    - line_start period 1688.
//  - One frame:
//    - frame_start period 1688*1066 = 1,799,408 clocks; 1024 lines contain disp_en.
//    - vsync active for 3*1688 = 5064 clocks, beginning at the first clock of line 1025.
//  - Reset mid-frame at line 500, x=700 -> one clock later all reset values. After release the
//    first frame has the full 1,799,408-clock period.
//  - Small-mode run: H_ACT=8, H_FP=2, H_SW=3, H_BP=1, V_ACT=4, V_FP=1, V_SW=2, V_BP=1,
//    HS_POL=VS_POL=0 -> line 14 clocks, frame 112 clocks, hsync low clocks 10-12 of each line;
//    compare against a cycle-accurate scoreboard for 3 frames.
//  - Continuous check across 2 frames: x,y both 0 whenever disp_en=0, and y never exceeds 1023.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster interface between the timing generator (master) and the pattern blocks (slave).
// All signals live in the VGA_CLK domain and change together, one clock after the counters.
interface vga_timing_gen_if;
  logic [10:0] x;
  logic [10:0] y;
  logic        disp_en;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;

  modport master (
    output x, y, disp_en, hsync, vsync, line_start, frame_start
  );

  modport slave (
    input x, y, disp_en, hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: free-running h/v counters decoded into registered
// coordinates, display enable, sync pulses and line/frame start strobes.
module vga_timing_gen #(
  parameter int H_ACT  = 1280,
  parameter int H_FP   = 48,
  parameter int H_SW   = 112,
  parameter int H_BP   = 248,
  parameter int V_ACT  = 1024,
  parameter int V_FP   = 1,
  parameter int V_SW   = 3,
  parameter int V_BP   = 38,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic              VGA_CLK,
  input  logic              reset,
  vga_timing_gen_if.master  vga_o
);

  localparam logic [10:0] H_FP_START = 11'(H_ACT);
  localparam logic [10:0] H_SW_START = 11'(H_ACT + H_FP);
  localparam logic [10:0] H_BP_START = 11'(H_ACT + H_FP + H_SW);
  localparam logic [10:0] H_LAST     = 11'(H_ACT + H_FP + H_SW + H_BP - 1);
  localparam logic [10:0] V_FP_START = 11'(V_ACT);
  localparam logic [10:0] V_SW_START = 11'(V_ACT + V_FP);
  localparam logic [10:0] V_BP_START = 11'(V_ACT + V_FP + V_SW);
  localparam logic [10:0] V_LAST     = 11'(V_ACT + V_FP + V_SW + V_BP - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

  function automatic phase_e decodePhase(
    input logic [10:0] cnt,
    input logic [10:0] fpStart,
    input logic [10:0] swStart,
    input logic [10:0] bpStart
  );
    if (cnt < fpStart) begin
      return PH_ACTIVE;
    end else if (cnt < swStart) begin
      return PH_FRONT;
    end else if (cnt < bpStart) begin
      return PH_SYNC;
    end else begin
      return PH_BACK;
    end
  endfunction

  logic [10:0] hCnt_q, hCnt_d;
  logic [10:0] vCnt_q, vCnt_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        dispEn_q, dispEn_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        lineStart_q, lineStart_d;
  logic        frameStart_q, frameStart_d;
  phase_e      hPhase, vPhase;

  // Outputs decode the current counters, so they trail the counters by one clock.
  always_comb begin
    hCnt_d       = hCnt_q + 11'd1;
    vCnt_d       = vCnt_q;
    hPhase       = decodePhase(hCnt_q, H_FP_START, H_SW_START, H_BP_START);
    vPhase       = decodePhase(vCnt_q, V_FP_START, V_SW_START, V_BP_START);
    dispEn_d     = 1'b0;
    x_d          = '0;
    y_d          = '0;
    hsync_d      = ~HS_POL;
    vsync_d      = ~VS_POL;
    lineStart_d  = 1'b0;
    frameStart_d = 1'b0;

    if (hCnt_q == H_LAST) begin
      hCnt_d = '0;
      vCnt_d = (vCnt_q == V_LAST) ? 11'd0 : vCnt_q + 11'd1;
    end

    if ((hPhase == PH_ACTIVE) && (vPhase == PH_ACTIVE)) begin
      dispEn_d = 1'b1;
      x_d      = hCnt_q;
      y_d      = vCnt_q;
    end

    if (hPhase == PH_SYNC) begin
      hsync_d = HS_POL;
    end
    if (vPhase == PH_SYNC) begin
      vsync_d = VS_POL;
    end

    lineStart_d  = (hCnt_q == 11'd0);
    frameStart_d = (hCnt_q == 11'd0) && (vCnt_q == 11'd0);
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      hCnt_q       <= '0;
      vCnt_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      dispEn_q     <= 1'b0;
      hsync_q      <= ~HS_POL;
      vsync_q      <= ~VS_POL;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dispEn_q     <= dispEn_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      lineStart_q  <= lineStart_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign vga_o.x           = x_q;
  assign vga_o.y           = y_q;
  assign vga_o.disp_en     = dispEn_q;
  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.line_start  = lineStart_q;
  assign vga_o.frame_start = frameStart_q;

endmodule
